// File: rtl/sd_phy_cmd_resp_rx.sv
`default_nettype none
// ============================================================================
// Module   : sd_phy_cmd_resp_rx
// Purpose  : SD card CMD-line response receiver. After a start pulse it waits
//            for the card's start bit (bounded by TIMEOUT_CYCLES sample
//            strobes), shifts in a 48-bit (or, optionally, 136-bit R2)
//            response MSB first, checks CRC7 and framing, and reports the
//            result with a one-cycle done pulse.
// Config   : SD_RESP_R2_EN -- when defined, the 136-bit R2 path is built and
//            long_resp selects it; when undefined all responses are 48-bit,
//            long_resp is ignored and resp_long reads 0.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous active-high reset
//            sample_en  - one-cycle strobe at the SD-clock sample point
//            cmd_in     - synchronized CMD line level
//            start      - one-cycle pulse arming reception (ignored if busy)
//            long_resp  - 1 = 136-bit R2 response, captured with start
//            check_crc  - 0 = skip CRC check (R3), captured with start
//            busy       - reception in progress (WAIT_START / RECV)
//            done       - one-cycle completion pulse
//            resp_index - response bits [45:40]
//            resp_arg   - response bits [39:8]
//            resp_long  - R2 bits [127:0] (bit 0 = end bit)
//            crc_err, frame_err, timeout - status flags, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module sd_phy_cmd_resp_rx #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_en,
    input  logic         cmd_in,
    input  logic         start,
    input  logic         long_resp,
    input  logic         check_crc,
    output logic         busy,
    output logic         done,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [127:0] resp_long,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout
);

`ifdef SD_RESP_R2_EN
    localparam int SR_W = 136;
`else
    localparam int SR_W = 48;
`endif
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECV       = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              chk_q, chk_d;
    logic [7:0]        bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [6:0]        crc_q, crc_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [5:0]        index_q, index_d;
    logic [31:0]       arg_q, arg_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_q, timeout_d;

    logic [SR_W-1:0]   w_frame;
    logic              w_is_long;
    logic              w_trans_bit;
    logic [7:0]        w_len;
    logic [7:0]        w_last;
    logic [7:0]        w_pos;
    logic              w_crc_bit;
    logic              w_inv;
    logic [6:0]        w_crc_next;
    logic [TO_W-1:0]   w_to_next;
    logic              w_unused;

`ifdef SD_RESP_R2_EN
    logic              long_q, long_d;
    logic [127:0]      resp_long_q, resp_long_d;

    assign w_is_long   = long_q;
    assign w_trans_bit = long_q ? w_frame[134] : w_frame[46];
    assign resp_long   = resp_long_q;
    assign w_unused    = shift_q[SR_W-1];
`else
    assign w_is_long   = 1'b0;
    assign w_trans_bit = w_frame[46];
    assign resp_long   = '0;
    assign w_unused    = ^{long_resp, shift_q[SR_W-1]};
`endif

    // Frame as it will look once the current bit is shifted in; on the
    // end-bit strobe this is the complete response.
    assign w_frame    = {shift_q[SR_W-2:0], cmd_in};
    assign w_len      = w_is_long ? 8'd136 : 8'd48;
    assign w_last     = w_len - 8'd1;
    // Bit position (within the response) of the bit arriving now.
    assign w_pos      = w_last - bit_cnt_q;
    // CRC covers bits down to 8; for R2 the 8-bit header above bit 127 is
    // excluded. The start bit is never fed in, which is harmless because a
    // zero bit into a zero CRC leaves it zero.
    assign w_crc_bit  = (w_pos >= 8'd8) && (w_pos <= 8'd127);
    assign w_inv      = cmd_in ^ crc_q[6];
    assign w_crc_next = {crc_q[5:3], crc_q[2] ^ w_inv, crc_q[1:0], w_inv};
    assign w_to_next  = to_cnt_q + TO_W'(1);

    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        index_d     = index_q;
        arg_d       = arg_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
`ifdef SD_RESP_R2_EN
        long_d      = long_q;
        resp_long_d = resp_long_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A sample strobe coinciding with start is deliberately unused.
                if (start) begin
                    state_d     = S_WAIT_START;
                    chk_d       = check_crc;
`ifdef SD_RESP_R2_EN
                    long_d      = long_resp;
`endif
                    bit_cnt_d   = 8'd0;
                    to_cnt_d    = '0;
                    crc_d       = 7'd0;
                    shift_d     = '0;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    timeout_d   = 1'b0;
                end
            end

            S_WAIT_START: begin
                if (sample_en) begin
                    if (!cmd_in) begin
                        state_d   = S_RECV;
                        bit_cnt_d = 8'd1;
                        shift_d   = w_frame;
                    end else begin
                        to_cnt_d = w_to_next;
                        if (w_to_next == TO_W'(TIMEOUT_CYCLES)) begin
                            timeout_d = 1'b1;
                            state_d   = S_DONE;
                        end
                    end
                end
            end

            S_RECV: begin
                if (sample_en) begin
                    shift_d   = w_frame;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (w_crc_bit) begin
                        crc_d = w_crc_next;
                    end
                    if (bit_cnt_q == w_last) begin
                        state_d     = S_DONE;
                        frame_err_d = w_trans_bit | ~w_frame[0];
                        crc_err_d   = chk_q & (w_frame[7:1] != crc_q);
`ifdef SD_RESP_R2_EN
                        if (long_q) begin
                            resp_long_d = w_frame[127:0];
                        end else begin
                            index_d = w_frame[45:40];
                            arg_d   = w_frame[39:8];
                        end
`else
                        index_d = w_frame[45:40];
                        arg_d   = w_frame[39:8];
`endif
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            chk_q       <= 1'b0;
            bit_cnt_q   <= 8'd0;
            to_cnt_q    <= '0;
            crc_q       <= 7'd0;
            shift_q     <= '0;
            index_q     <= 6'd0;
            arg_q       <= 32'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef SD_RESP_R2_EN
            long_q      <= 1'b0;
            resp_long_q <= 128'd0;
`endif
        end else begin
            state_q     <= state_d;
            chk_q       <= chk_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
`ifdef SD_RESP_R2_EN
            long_q      <= long_d;
            resp_long_q <= resp_long_d;
`endif
        end
    end

    assign busy       = (state_q == S_WAIT_START) || (state_q == S_RECV);
    assign done       = (state_q == S_DONE);
    assign resp_index = index_q;
    assign resp_arg   = arg_q;
    assign crc_err    = crc_err_q;
    assign frame_err  = frame_err_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_phy_cmd_resp_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sd_phy_cmd_resp_rx
// Purpose  : Self-checking bench for sd_phy_cmd_resp_rx (default 48-bit build).
//            Table of response frames plus hand-written timeout, reset and
//            start-collision sequences; expected results are queued when a
//            frame is driven and compared when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_phy_cmd_resp_rx;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_en = 1'b0;
    logic         cmd_in = 1'b1;
    logic         start = 1'b0;
    logic         long_resp = 1'b0;
    logic         check_crc = 1'b0;
    logic         busy, done;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic [127:0] resp_long;
    logic         crc_err, frame_err, timeout;

    sd_phy_cmd_resp_rx #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .cmd_in(cmd_in),
        .start(start), .long_resp(long_resp), .check_crc(check_crc),
        .busy(busy), .done(done), .resp_index(resp_index), .resp_arg(resp_arg),
        .resp_long(resp_long), .crc_err(crc_err), .frame_err(frame_err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] frame;
        bit          chk;
        bit          lr;
        int          idle;
        bit          start_smp;
        bit          mid_start;
        logic [5:0]  idx;
        logic [31:0] arg;
        bit          ce;
        bit          fe;
    } vec_t;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        bit          ce;
        bit          fe;
        bit          to;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    logic [5:0]  last_idx = 6'd0;
    logic [31:0] last_arg = 32'd0;
    vec_t        vecs[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Classic shift-left CRC7 with polynomial 0x09 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c = 7'd0;
        logic       fb;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic vec_t mk(input logic [47:0] f, input bit chk, input bit lr,
                                input int idle, input bit ss, input bit ms,
                                input logic [5:0] idx, input logic [31:0] arg,
                                input bit ce, input bit fe);
        vec_t v;
        v.frame = f; v.chk = chk; v.lr = lr; v.idle = idle; v.start_smp = ss;
        v.mid_start = ms; v.idx = idx; v.arg = arg; v.ce = ce; v.fe = fe;
        return v;
    endfunction

    // Scoreboard side: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending response");
            end else begin
                mon_e = q.pop_front();
                check("resp_index", {122'd0, resp_index}, {122'd0, mon_e.idx});
                check("resp_arg",   {96'd0, resp_arg},    {96'd0, mon_e.arg});
                check("crc_err",    {127'd0, crc_err},    {127'd0, mon_e.ce});
                check("frame_err",  {127'd0, frame_err},  {127'd0, mon_e.fe});
                check("timeout",    {127'd0, timeout},    {127'd0, mon_e.to});
                check("resp_long",  resp_long,            128'd0);
            end
        end
    end

    // All drivers run from posedge+1; each returns at posedge+1.
    task automatic strobe(input bit b);
        cmd_in    = b;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_pulse(input bit chk, input bit lr, input bit with_sample);
        start     = 1'b1;
        check_crc = chk;
        long_resp = lr;
        if (with_sample) begin
            sample_en = 1'b1;
            cmd_in    = 1'b0;
        end
        @(posedge clk); #1;
        start     = 1'b0;
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        long_resp = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string name);
        int k = 0;
        while (done_cnt == n0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, 128'(done_cnt - n0), 128'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        int   n0;
        e.idx = v.idx; e.arg = v.arg; e.ce = v.ce; e.fe = v.fe; e.to = 1'b0;
        q.push_back(e);
        last_idx = v.idx;
        last_arg = v.arg;
        n0 = done_cnt;
        start_pulse(v.chk, v.lr, v.start_smp);
        repeat (v.idle) strobe(1'b1);
        for (int i = 47; i >= 0; i--) begin
            if (v.mid_start && i == 20) begin
                start     = 1'b1;
                check_crc = ~v.chk;
            end
            strobe(v.frame[i]);
            start     = 1'b0;
            check_crc = v.chk;
        end
        wait_done(n0, name);
    endtask

    initial begin : main
        logic [39:0] gd;
        logic [47:0] r7;
        exp_t        te;
        int          n0;

        r7 = {8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        gd = {2'b00, 6'h11, 32'hDEADBEEF};

        vecs[0] = mk(r7, 1, 0, 5, 0, 0, 6'h08, 32'h000001AA, 0, 0);
        vecs[1] = mk({r7[47:8], 8'h15}, 1, 0, 5, 0, 1, 6'h08, 32'h000001AA, 1, 0);
        vecs[2] = mk({8'h3F, 8'h00, 8'hFF, 8'h80, 8'h00, 8'hFF}, 0, 1, 5, 0, 0,
                     6'h3F, 32'h00FF8000, 0, 0);
        vecs[3] = mk({r7[47:8], 8'h12}, 1, 0, 5, 0, 0, 6'h08, 32'h000001AA, 0, 1);
        vecs[4] = mk({8'h48, r7[39:0]}, 0, 0, 2, 0, 0, 6'h08, 32'h000001AA, 0, 1);
        vecs[5] = mk(r7, 1, 0, 0, 1, 0, 6'h08, 32'h000001AA, 0, 0);
        vecs[6] = mk({gd, crc7(gd), 1'b1}, 1, 0, 3, 0, 0, 6'h11, 32'hDEADBEEF, 0, 0);
        vecs[7] = mk({gd, crc7(gd) ^ 7'h01, 1'b1}, 1, 0, 3, 0, 0, 6'h11, 32'hDEADBEEF, 1, 0);
        vecs[8] = mk(r7, 1, 0, 63, 0, 0, 6'h08, 32'h000001AA, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {127'd0, busy},       128'd0);
        check("rst_done",  {127'd0, done},       128'd0);
        check("rst_index", {122'd0, resp_index}, 128'd0);
        check("rst_arg",   {96'd0, resp_arg},    128'd0);
        check("rst_long",  resp_long,            128'd0);
        check("rst_flags", {125'd0, crc_err, frame_err, timeout}, 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d_done_once", i));

        // Timeout: CMD held high for 64 strobes; outputs from the last frame hold.
        te.idx = last_idx; te.arg = last_arg; te.ce = 0; te.fe = 0; te.to = 1;
        q.push_back(te);
        n0 = done_cnt;
        start_pulse(1'b1, 1'b0, 1'b0);
        check("to_busy_armed", {127'd0, busy}, 128'd1);
        repeat (63) strobe(1'b1);
        check("to_no_done_at_63", 128'(done_cnt - n0), 128'd0);
        check("to_busy_at_63", {127'd0, busy}, 128'd1);
        cmd_in    = 1'b1;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        check("to_done_next_cycle", {127'd0, done}, 128'd1);
        @(posedge clk); #1;
        check("to_busy_after", {127'd0, busy}, 128'd0);
        wait_done(n0, "to_done_once");

        // Reset in the middle of reception: no done, everything cleared.
        n0 = done_cnt;
        start_pulse(1'b1, 1'b0, 1'b0);
        repeat (3) strobe(1'b1);
        for (int i = 47; i >= 28; i--) strobe(r7[i]);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy",  {127'd0, busy},       128'd0);
        check("mid_rst_done",  {127'd0, done},       128'd0);
        check("mid_rst_index", {122'd0, resp_index}, 128'd0);
        check("mid_rst_arg",   {96'd0, resp_arg},    128'd0);
        check("mid_rst_flags", {125'd0, crc_err, frame_err, timeout}, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_done", 128'(done_cnt - n0), 128'd0);
        check("mid_rst_idle", {127'd0, busy}, 128'd0);

        run_vec(vecs[0], "post_rst_done_once");

        check("queue_empty", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard wall-clock guard in case a driver loop ever stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/sd_phy_cmd_resp_rx.md
SD_PHY_CMD_RESP_RX -- requirements
Module: sd_phy_cmd_resp_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the max sample strobes waited for a start bit (NCR limit).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sample_en  input  1  one-cycle strobe marking the SD-clock sample point for cmd_in.
REQ-005 SHALL have port cmd_in  input  1  synchronized CMD line level.
REQ-006 SHALL have port start  input  1  one-cycle pulse arming reception.
REQ-007 SHALL have port long_resp  input  1  1 = 136-bit R2 response; captured with start.
REQ-008 SHALL have port check_crc  input  1  0 = skip CRC check (R3); captured with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_index  output  6  response bits [45:40].
REQ-012 SHALL have port resp_arg  output  32  response bits [39:8].
REQ-013 SHALL have port resp_long  output  128  R2 bits [127:0] (bit 0 = end bit).
REQ-014 SHALL have ports crc_err, frame_err, timeout  output  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, WAIT_START, RECV, DONE; all state changes except reset occur only on sample_en cycles, except IDLE->WAIT_START (on start) and DONE->IDLE (next cycle).
REQ-016 start in IDLE SHALL capture long_resp/check_crc, clear all status flags, clear the CRC and timeout counter, and enter WAIT_START; start when busy SHALL be ignored.
REQ-017 WAIT_START: sample_en with cmd_in=0 SHALL enter RECV with bit counter 1 (start bit counted); otherwise the timeout counter increments, and on reaching TIMEOUT_CYCLES SHALL set timeout=1 and enter DONE.
REQ-018 RECV SHALL shift one bit per sample_en, MSB first, into a 48-bit or 136-bit register until the total length incl. start bit is reached.
REQ-019 CRC7 SHALL use polynomial x^7+x^3+1, initial 0, serial: inv = bit ^ crc[6]; crc <= {crc[5:3], crc[2]^inv, crc[1:0], inv}.
REQ-020 48-bit: CRC SHALL cover bits [47:8]; R2: CRC SHALL cover bits [127:8] only; result compared with received bits [7:1].
REQ-021 crc_err SHALL be 1 iff check_crc was 1 and the comparison fails.
REQ-022 frame_err SHALL be 1 iff transmission bit (bit 46 / bit 134) is not 0 or end bit is not 1.
REQ-023 On the end-bit sample_en, resp_index, resp_arg (48-bit) or resp_long (R2), and flags SHALL be registered; done SHALL pulse in the following cycle (DONE state).
REQ-024 Outputs and flags SHALL hold their values until the next accepted start; done SHALL be high exactly one cycle per start, including timeout.
REQ-025 sample_en and start in the same cycle in IDLE: start is accepted; that sample is not used.

Reset
REQ-026 reset SHALL asynchronously force IDLE, busy=0, done=0, all flags 0, resp_index=0, resp_arg=0, resp_long=0, CRC and counters 0, including mid-RECV.

Configuration
REQ-027 Macro SD_RESP_R2_EN: defined -> 136-bit R2 path and 136-bit shift register present; undefined -> long_resp ignored, all responses 48-bit, resp_long tied to 0.

Verification
REQ-028 R7: bytes 08 00 00 01 AA 13 after 5 idle-high strobes -> done, resp_index=0x08, resp_arg=0x000001AA, crc_err=0, frame_err=0, timeout=0.
REQ-029 Same with last byte 0x15 -> crc_err=1, frame_err=0, resp_arg=0x000001AA.
REQ-030 R3 with check_crc=0: bytes 3F 00 FF 80 00 FF -> resp_index=0x3F, resp_arg=0x00FF8000, crc_err=0, frame_err=0.
REQ-031 cmd_in held 1 after start -> done with timeout=1 on the cycle after the 64th sample_en; busy low afterwards.
REQ-032 R7 frame with end bit 0 (last byte 0x12) -> frame_err=1, crc_err=0.
REQ-033 reset asserted after 20 received bits -> busy=0 immediately, no done; subsequent start plus REQ-028 frame -> correct result.
